// File: rtl/vm_pkg.sv
// Shared constants and types for the change dispenser: coin_sel encoding,
// default denominations and the dispenser state enum. Optional macro CHANGE_STOCK_EN.
package vm_pkg;

    localparam int unsigned AMT_W = 8;

    localparam logic [1:0] SEL_DEN0 = 2'd0;
    localparam logic [1:0] SEL_DEN1 = 2'd1;
    localparam logic [1:0] SEL_DEN2 = 2'd2;
    localparam logic [1:0] SEL_DEN3 = 2'd3;

    localparam int unsigned DEF_DEN0 = 50;
    localparam int unsigned DEF_DEN1 = 10;
    localparam int unsigned DEF_DEN2 = 5;
    localparam int unsigned DEF_DEN3 = 1;

    typedef enum logic [1:0] {
        StIdle,
        StPick,
        StSend,
        StDone
    } disp_state_e;

endpackage

// File: rtl/coin_picker.sv
// Greedy priority selector: largest denomination that still fits the remaining amount.
// Under CHANGE_STOCK_EN, denominations with an empty stock counter are skipped.
module coin_picker #(
    parameter int unsigned AMT_W = vm_pkg::AMT_W,
    parameter int unsigned DEN0  = vm_pkg::DEF_DEN0,
    parameter int unsigned DEN1  = vm_pkg::DEF_DEN1,
    parameter int unsigned DEN2  = vm_pkg::DEF_DEN2,
    parameter int unsigned DEN3  = vm_pkg::DEF_DEN3
) (
`ifdef CHANGE_STOCK_EN
    input  logic [3:0]       stock_nz,
`endif
    input  logic [AMT_W-1:0] remaining,
    output logic [1:0]       sel,
    output logic             found
);
    import vm_pkg::*;

    logic [3:0] fits;

    always_comb begin
        fits[0] = remaining >= AMT_W'(DEN0);
        fits[1] = remaining >= AMT_W'(DEN1);
        fits[2] = remaining >= AMT_W'(DEN2);
        fits[3] = remaining >= AMT_W'(DEN3);
`ifdef CHANGE_STOCK_EN
        fits = fits & stock_nz;
`endif
        found = |fits;
        sel   = SEL_DEN0;
        if (fits[0])      sel = SEL_DEN0;
        else if (fits[1]) sel = SEL_DEN1;
        else if (fits[2]) sel = SEL_DEN2;
        else if (fits[3]) sel = SEL_DEN3;
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount one coin at a time, largest denomination first.
// Define CHANGE_STOCK_EN to add per-denomination stock counters and shortfall reporting.
module change_dispenser #(
    parameter int unsigned AMT_W = vm_pkg::AMT_W,
    parameter int unsigned DEN0  = vm_pkg::DEF_DEN0,
    parameter int unsigned DEN1  = vm_pkg::DEF_DEN1,
    parameter int unsigned DEN2  = vm_pkg::DEF_DEN2,
    parameter int unsigned DEN3  = vm_pkg::DEF_DEN3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AMT_W-1:0] req_amount,
    output logic             coin_valid,
    input  logic             coin_ready,
    output logic [1:0]       coin_sel,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] remaining,
    output logic [AMT_W-1:0] coins_sent,
    output logic             short
`ifdef CHANGE_STOCK_EN
    ,
    input  logic             stock_load,
    input  logic [1:0]       stock_idx,
    input  logic [AMT_W-1:0] stock_val
`endif
);
    import vm_pkg::*;

    disp_state_e      state;
    logic [1:0]       pick_sel;
    logic             pick_found;
    logic [AMT_W-1:0] coin_den;

    always_comb begin
        coin_den = AMT_W'(DEN3);
        unique case (coin_sel)
            SEL_DEN0: coin_den = AMT_W'(DEN0);
            SEL_DEN1: coin_den = AMT_W'(DEN1);
            SEL_DEN2: coin_den = AMT_W'(DEN2);
            SEL_DEN3: coin_den = AMT_W'(DEN3);
            default:  coin_den = AMT_W'(DEN3);
        endcase
    end

`ifdef CHANGE_STOCK_EN
    logic [3:0][AMT_W-1:0] stock;
    logic [3:0]            stock_nz;
    logic                  short_q;

    always_comb begin
        for (int i = 0; i < 4; i++) stock_nz[i] = stock[i] != '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stock <= '0;
        end else if (state == StIdle && stock_load) begin
            stock[stock_idx] <= stock_val;
        end else if (state == StSend && coin_ready) begin
            stock[coin_sel] <= stock[coin_sel] - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            short_q <= 1'b0;
        end else if (state == StIdle && req_valid) begin
            short_q <= 1'b0;
        end else if (state == StPick && !pick_found) begin
            short_q <= 1'b1;
        end
    end

    assign short = short_q;

    coin_picker #(
        .AMT_W (AMT_W),
        .DEN0  (DEN0),
        .DEN1  (DEN1),
        .DEN2  (DEN2),
        .DEN3  (DEN3)
    ) u_picker (
        .stock_nz  (stock_nz),
        .remaining (remaining),
        .sel       (pick_sel),
        .found     (pick_found)
    );
`else
    assign short = 1'b0;

    coin_picker #(
        .AMT_W (AMT_W),
        .DEN0  (DEN0),
        .DEN1  (DEN1),
        .DEN2  (DEN2),
        .DEN3  (DEN3)
    ) u_picker (
        .remaining (remaining),
        .sel       (pick_sel),
        .found     (pick_found)
    );
`endif

    // All handshake/status outputs are registered and change with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            coin_valid <= 1'b0;
            coin_sel   <= SEL_DEN0;
            done       <= 1'b0;
            remaining  <= '0;
            coins_sent <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req_valid) begin
                        remaining  <= req_amount;
                        coins_sent <= '0;
                        req_ready  <= 1'b0;
                        busy       <= 1'b1;
                        if (req_amount == '0) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end else begin
                            state <= StPick;
                        end
                    end
                end
                StPick: begin
                    if (pick_found) begin
                        coin_sel   <= pick_sel;
                        coin_valid <= 1'b1;
                        state      <= StSend;
                    end else begin
                        state <= StDone;
                        done  <= 1'b1;
                    end
                end
                StSend: begin
                    if (coin_ready) begin
                        remaining  <= remaining - coin_den;
                        coins_sent <= coins_sent + 1'b1;
                        coin_valid <= 1'b0;
                        if (remaining == coin_den) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end else begin
                            state <= StPick;
                        end
                    end
                end
                StDone: begin
                    state     <= StIdle;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser against a counting model of greedy payout.
// Define CHANGE_STOCK_EN to also exercise the stock counters and shortfall.
module tb_change_dispenser;

    localparam int DENS [4] = '{50, 10, 5, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_amount = 8'd0;
    logic       coin_valid;
    logic       coin_ready = 1'b0;
    logic [1:0] coin_sel;
    logic       busy;
    logic       done;
    logic [7:0] remaining;
    logic [7:0] coins_sent;
    logic       short;
`ifdef CHANGE_STOCK_EN
    logic       stock_load = 1'b0;
    logic [1:0] stock_idx = 2'd0;
    logic [7:0] stock_val = 8'd0;
`endif

    change_dispenser dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_amount (req_amount),
        .coin_valid (coin_valid),
        .coin_ready (coin_ready),
        .coin_sel   (coin_sel),
        .busy       (busy),
        .done       (done),
        .remaining  (remaining),
        .coins_sent (coins_sent),
        .short      (short)
`ifdef CHANGE_STOCK_EN
        ,
        .stock_load (stock_load),
        .stock_idx  (stock_idx),
        .stock_val  (stock_val)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int exp_sel[$];
    int obs_sel[$];
    int model_stock[4] = '{0, 0, 0, 0};
    int obs_first_cv;
    int obs_done_cyc;
    int obs_ndone;
    bit obs_timeout;

    // Greedy payout as per-denomination counts; returns the amount left unpaid.
    function automatic int model_payout(input int amt);
        int rem;
        rem = amt;
        exp_sel.delete();
        for (int i = 0; i < 4; i++) begin
            int n;
            n = rem / DENS[i];
`ifdef CHANGE_STOCK_EN
            if (n > model_stock[i]) n = model_stock[i];
            model_stock[i] -= n;
`endif
            for (int k = 0; k < n; k++) exp_sel.push_back(i);
            rem -= n * DENS[i];
        end
        return rem;
    endfunction

    task automatic load_stock(input int idx, input int val);
`ifdef CHANGE_STOCK_EN
        stock_load = 1'b1;
        stock_idx  = 2'(idx);
        stock_val  = 8'(val);
        @(negedge clk);
        stock_load = 1'b0;
        model_stock[idx] = val;
`else
        if (idx < 0 || val < 0) $display("note: negative stock argument ignored");
`endif
    endtask

    task automatic prime_stock();
        for (int i = 0; i < 4; i++) load_stock(i, 255);
    endtask

    // Issues one request and records coins, first coin_valid cycle and done cycle.
    task automatic do_payout(input int amt, input int stall_pct);
        int guard;
        obs_sel.delete();
        obs_first_cv = -1;
        obs_done_cyc = -1;
        obs_ndone    = 0;
        obs_timeout  = 1'b1;
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        req_valid  = 1'b1;
        req_amount = 8'(amt);
        @(negedge clk);
        req_valid = 1'b0;
        for (int cyc = 1; cyc < 2000; cyc++) begin
            if (obs_done_cyc >= 0 && cyc == obs_done_cyc + 2) begin
                obs_timeout = 1'b0;
                break;
            end
            if (done) begin
                obs_ndone++;
                if (obs_done_cyc < 0) obs_done_cyc = cyc;
            end
            if (coin_valid) begin
                if (obs_first_cv < 0) obs_first_cv = cyc;
                coin_ready = ($urandom_range(99) >= stall_pct);
                if (coin_ready) obs_sel.push_back(int'(coin_sel));
            end else begin
                coin_ready = 1'($urandom_range(1));
            end
            @(negedge clk);
        end
        coin_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = 1'b1;
        req_amount = 8'd9;
        coin_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({req_ready, coin_valid, coin_sel, busy, done, remaining, coins_sent, short} !==
            {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b cv=%b sel=%0d busy=%b done=%b rem=%0d cnt=%0d short=%b, want 1 0 0 0 0 0 0 0",
                     req_ready, coin_valid, coin_sel, busy, done, remaining, coins_sent, short);
        end
        req_valid  = 1'b0;
        coin_ready = 1'b0;
        rst        = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_amount_87();
        int exp_rem;
        prime_stock();
        exp_rem = model_payout(87);
        do_payout(87, 0);
        n_cmp++;
        if (obs_sel.size() !== exp_sel.size()) begin
            n_err++;
            $display("FAIL p87_len: got %0d coins, want %0d", obs_sel.size(), exp_sel.size());
        end else begin
            for (int i = 0; i < exp_sel.size(); i++) begin
                n_cmp++;
                if (obs_sel[i] !== exp_sel[i]) begin
                    n_err++;
                    $display("FAIL p87_sel[%0d]: got %0d, want %0d", i, obs_sel[i], exp_sel[i]);
                end
            end
        end
        n_cmp++;
        if ({coins_sent, remaining} !== {8'd7, 8'(exp_rem)}) begin
            n_err++;
            $display("FAIL p87_final: got cnt=%0d rem=%0d, want cnt=7 rem=%0d", coins_sent, remaining, exp_rem);
        end
        n_cmp++;
        if (obs_ndone !== 1 || obs_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL p87_done: got %0d pulses timeout=%b, want 1 pulse", obs_ndone, obs_timeout);
        end
        n_cmp++;
        if (obs_first_cv !== 2 || obs_done_cyc !== 15) begin
            n_err++;
            $display("FAIL p87_latency: got first_cv=%0d done=%0d, want 2 and 15", obs_first_cv, obs_done_cyc);
        end
    endtask

    task automatic test_zero();
        do_payout(0, 0);
        n_cmp++;
        if (obs_done_cyc !== 1 || obs_ndone !== 1) begin
            n_err++;
            $display("FAIL zero_done: got cycle=%0d pulses=%0d, want cycle=1 pulses=1", obs_done_cyc, obs_ndone);
        end
        n_cmp++;
        if (obs_first_cv !== -1 || coins_sent !== 8'd0) begin
            n_err++;
            $display("FAIL zero_coins: got first_cv=%0d cnt=%0d, want none and 0", obs_first_cv, coins_sent);
        end
    endtask

    task automatic test_stall();
        int guard;
        prime_stock();
        req_valid  = 1'b1;
        req_amount = 8'd60;
        @(negedge clk);
        req_valid  = 1'b0;
        coin_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if ({coin_valid, coin_sel, remaining} !== {1'b1, 2'd0, 8'd60}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got cv=%b sel=%0d rem=%0d, want 1 0 60", k, coin_valid, coin_sel, remaining);
            end
            if (k < 5) @(negedge clk);
        end
        coin_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({coin_valid, remaining, coins_sent} !== {1'b0, 8'd10, 8'd1}) begin
            n_err++;
            $display("FAIL stall_release: got cv=%b rem=%0d cnt=%0d, want 0 10 1", coin_valid, remaining, coins_sent);
        end
        guard = 0;
        while (!done && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        coin_ready = 1'b0;
        n_cmp++;
        if ({done, remaining, coins_sent} !== {1'b1, 8'd0, 8'd2}) begin
            n_err++;
            $display("FAIL stall_final: got done=%b rem=%0d cnt=%0d, want 1 0 2", done, remaining, coins_sent);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_busy();
        int guard;
        prime_stock();
        obs_sel.delete();
        req_valid  = 1'b1;
        req_amount = 8'd15;
        @(negedge clk);
        req_valid  = 1'b0;
        coin_ready = 1'b1;
        @(negedge clk);
        req_valid  = 1'b1;
        req_amount = 8'd30;
        n_cmp++;
        if (req_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL ignore_ready: got rdy=%b busy=%b, want 0 1", req_ready, busy);
        end
        guard = 0;
        while (!done && guard < 50) begin
            if (coin_valid) obs_sel.push_back(int'(coin_sel));
            @(negedge clk);
            req_valid = 1'b0;
            guard++;
        end
        coin_ready = 1'b0;
        n_cmp++;
        if (obs_sel.size() !== 2 || obs_sel[0] !== 1 || obs_sel[1] !== 2) begin
            n_err++;
            $display("FAIL ignore_seq: got %0d coins, want sel 1,2", obs_sel.size());
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, coins_sent, remaining} !== {1'b0, 8'd2, 8'd0}) begin
            n_err++;
            $display("FAIL ignore_after: got busy=%b cnt=%0d rem=%0d, want 0 2 0", busy, coins_sent, remaining);
        end
    endtask

    task automatic test_reset_mid();
        prime_stock();
        req_valid  = 1'b1;
        req_amount = 8'd55;
        @(negedge clk);
        req_valid  = 1'b0;
        coin_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b1;
        coin_ready = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        coin_ready = 1'b0;
        n_cmp++;
        if ({req_ready, coin_valid, coin_sel, busy, done, remaining, coins_sent, short} !==
            {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0}) begin
            n_err++;
            $display("FAIL midrst_outputs: got rdy=%b cv=%b sel=%0d busy=%b done=%b rem=%0d cnt=%0d, want idle reset values",
                     req_ready, coin_valid, coin_sel, busy, done, remaining, coins_sent);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL midrst_quiet[%0d]: got done=%b busy=%b, want 0 0", k, done, busy);
            end
        end
`ifdef CHANGE_STOCK_EN
        for (int i = 0; i < 4; i++) model_stock[i] = 0;
`endif
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            int amt;
            int stall;
            int exp_rem;
            int exp_done;
`ifdef CHANGE_STOCK_EN
            for (int i = 0; i < 4; i++) load_stock(i, $urandom_range(0, 6));
`else
            prime_stock();
`endif
            amt   = (it % 6 == 0) ? $urandom_range(0, 9) : $urandom_range(0, 255);
            stall = ($urandom_range(1) == 1) ? 0 : 40;
            exp_rem  = model_payout(amt);
            exp_done = (amt == 0) ? 1 : 2 * exp_sel.size() + 1 + ((exp_rem != 0) ? 1 : 0);
            do_payout(amt, stall);
            n_cmp++;
            if (obs_sel.size() !== exp_sel.size()) begin
                n_err++;
                $display("FAIL rnd%0d_len amt=%0d: got %0d coins, want %0d", it, amt, obs_sel.size(), exp_sel.size());
            end else begin
                for (int i = 0; i < exp_sel.size(); i++) begin
                    n_cmp++;
                    if (obs_sel[i] !== exp_sel[i]) begin
                        n_err++;
                        $display("FAIL rnd%0d_sel[%0d]: got %0d, want %0d", it, i, obs_sel[i], exp_sel[i]);
                    end
                end
            end
            n_cmp++;
            if ({coins_sent, remaining, short} !== {8'(exp_sel.size()), 8'(exp_rem), exp_rem != 0}) begin
                n_err++;
                $display("FAIL rnd%0d_final amt=%0d: got cnt=%0d rem=%0d short=%b, want %0d %0d %b",
                         it, amt, coins_sent, remaining, short, exp_sel.size(), exp_rem, exp_rem != 0);
            end
            n_cmp++;
            if (obs_ndone !== 1 || obs_timeout !== 1'b0) begin
                n_err++;
                $display("FAIL rnd%0d_done: got %0d pulses timeout=%b, want 1", it, obs_ndone, obs_timeout);
            end
            n_cmp++;
            if (obs_first_cv !== ((exp_sel.size() > 0) ? 2 : -1)) begin
                n_err++;
                $display("FAIL rnd%0d_first: got %0d, want %0d", it, obs_first_cv, (exp_sel.size() > 0) ? 2 : -1);
            end
            if (stall == 0) begin
                n_cmp++;
                if (obs_done_cyc !== exp_done) begin
                    n_err++;
                    $display("FAIL rnd%0d_donecyc: got %0d, want %0d", it, obs_done_cyc, exp_done);
                end
            end
        end
    endtask

`ifdef CHANGE_STOCK_EN
    task automatic test_stock();
        int exp_rem;
        load_stock(0, 0);
        load_stock(1, 2);
        load_stock(2, 5);
        load_stock(3, 0);
        exp_rem = model_payout(27);
        do_payout(27, 0);
        n_cmp++;
        if (obs_sel.size() !== 3 || obs_sel[0] !== 1 || obs_sel[1] !== 1 || obs_sel[2] !== 2) begin
            n_err++;
            $display("FAIL stock_seq: got %0d coins, want sel 1,1,2", obs_sel.size());
        end
        n_cmp++;
        if ({short, remaining, coins_sent} !== {1'b1, 8'(exp_rem), 8'd3}) begin
            n_err++;
            $display("FAIL stock_short: got short=%b rem=%0d cnt=%0d, want 1 %0d 3", short, remaining, coins_sent, exp_rem);
        end
        // Leftover stock {0,0,4,0}: a 9 request can only pay one 5.
        exp_rem = model_payout(9);
        do_payout(9, 0);
        n_cmp++;
        if ({obs_sel.size() == 1, short, remaining} !== {1'b1, 1'b1, 8'(exp_rem)}) begin
            n_err++;
            $display("FAIL stock_left: got %0d coins short=%b rem=%0d, want 1 coin 1 %0d", obs_sel.size(), short, remaining, exp_rem);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_amount_87();
        test_zero();
        test_stall();
        test_ignore_busy();
        test_reset_mid();
        test_random();
`ifdef CHANGE_STOCK_EN
        test_reset_mid();
        test_stock();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
